// File: rtl/tmr_ahb_arb.sv
// tmr_ahb_arb: round-robin arbiter and AHB-lite master for one shared peripheral slave.
// N requesters use a req/gnt/done handshake. The block runs one single 32-bit transfer
// at a time, with an address phase followed by a data phase.
// Optional build macro TMR_AHB_ARB_TIMEOUT_EN ends a stalled data phase with an error
// after TMO wait cycles.
module tmr_ahb_arb #(
  parameter int unsigned N   = 2,
  parameter int unsigned AW  = 5,
  parameter int unsigned TMO = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    req_we,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*32-1:0] req_wd,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    done,
  output logic [31:0]     rdata,
  output logic            err,
  output logic [AW-1:0]   haddr,
  output logic [31:0]     hwdata,
  input  logic [31:0]     hrdata,
  output logic            hwrite,
  output logic [1:0]      htrans,
  output logic [2:0]      hsize,
  output logic [2:0]      hburst,
  output logic            hsel,
  input  logic            hready,
  input  logic [1:0]      hresp,
  output logic            busy
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wd_q, wd_d;
  logic            found;
  logic            timeout;

  assign hsize  = 3'b010;
  assign hburst = 3'b000;
  assign busy   = (state_q != StIdle);

`ifdef TMR_AHB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TMO + 1);
  logic [CW-1:0] cnt_q;

  assign timeout = (cnt_q == CW'(TMO));

  // Wait-cycle counter; held at zero outside the data phase so it is clear on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q != StData) begin
      cnt_q <= '0;
    end else if (!hready && !timeout) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Round-robin pick: the lowest requesting index at or after the pointer, wrapping.
  always_comb begin
    int unsigned j;
    j      = 0;
    found  = 1'b0;
    win_d  = win_q;
    we_d   = we_q;
    addr_d = addr_q;
    wd_d   = wd_q;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        win_d  = IW'(j);
        we_d   = req_we[j];
        addr_d = req_addr[j*AW +: AW];
        wd_d   = req_wd[j*32 +: 32];
      end
    end
  end

  // The pointer moves past the winner once its grant has been issued.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StAddr) begin
      if (32'(win_q) == N - 1) ptr_d = '0;
      else                     ptr_d = win_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Arbitration pointer and captured request. The capture happens only in idle, so later
  // changes on req do not disturb a transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      win_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (state_q == StIdle && found) begin
        win_q  <= win_d;
        we_q   <= we_d;
        addr_q <= addr_d;
        wd_q   <= wd_d;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (found) state_d = StAddr;
      StAddr:  state_d = StData;
      StData:  if (hready || timeout) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: AHB phase signals and per-requester handshake pulses.
  always_comb begin
    gnt    = '0;
    done   = '0;
    rdata  = '0;
    err    = 1'b0;
    haddr  = '0;
    hwdata = '0;
    hwrite = 1'b0;
    htrans = 2'b00;
    hsel   = 1'b0;
    unique case (state_q)
      StAddr: begin
        hsel       = 1'b1;
        htrans     = 2'b10;
        haddr      = addr_q;
        hwrite     = we_q;
        gnt[win_q] = 1'b1;
      end
      StData: begin
        hwdata = wd_q;
        if (hready) begin
          done[win_q] = 1'b1;
          rdata       = we_q ? 32'h0 : hrdata;
          err         = (hresp != 2'b00);
        end else if (timeout) begin
          done[win_q] = 1'b1;
          err         = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
